// File: rtl/score_sequencer.sv
// score_sequencer: per-note controller around the combinational scorer.
// It fetches each goal note from the chart and waits for a key press or a
// miss timeout. It then holds the press/goal pair on sc_* for the scorer and
// commits the scorer outputs into saturating running totals.
// Ports: clk/rst (sync, active-high), start/abort control, total_note,
//   game_time, press_* key input, chart_* fetch handshake, sc_* scorer
//   interface (feedback out, results in), total_score/combo/note_cnt/acc/
//   level results, busy/done status.
// Optional: define MAX_COMBO_EN to add the max_combo output.
module score_sequencer #(
  parameter int CLOCK_W   = 21,
  parameter int OCTAVE_W  = 2,
  parameter int NOTE_W    = 4,
  parameter int LENGTH_W  = 3,
  parameter int MISS_WIN  = 188,
  parameter int EARLY_WIN = 188,
  parameter int TOTAL_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [20:0]         total_note,
  input  logic [CLOCK_W-1:0]  game_time,
  input  logic                press_valid,
  input  logic [OCTAVE_W-1:0] press_octave,
  input  logic [NOTE_W-1:0]   press_note,
  input  logic [LENGTH_W-1:0] press_length,
  output logic                chart_req,
  output logic [20:0]         chart_idx,
  input  logic                chart_valid,
  input  logic [CLOCK_W-1:0]  chart_clock,
  input  logic [OCTAVE_W-1:0] chart_octave,
  input  logic [NOTE_W-1:0]   chart_note,
  input  logic [LENGTH_W-1:0] chart_length,
  output logic [CLOCK_W-1:0]  sc_clock,
  output logic [OCTAVE_W-1:0] sc_octave,
  output logic [NOTE_W-1:0]   sc_note,
  output logic [LENGTH_W-1:0] sc_length,
  output logic [CLOCK_W-1:0]  sc_goal_clock,
  output logic [OCTAVE_W-1:0] sc_goal_octave,
  output logic [NOTE_W-1:0]   sc_goal_note,
  output logic [LENGTH_W-1:0] sc_goal_length,
  output logic [20:0]         sc_last_combo,
  output logic [20:0]         sc_now_cnt,
  output logic [20:0]         sc_total_note,
  output logic [20:0]         sc_last_base_score,
  input  logic [20:0]         sc_base_score,
  input  logic [20:0]         sc_bonus_score,
  input  logic [20:0]         sc_combo,
  input  logic [20:0]         sc_acc,
  input  logic [2:0]          sc_level,
  output logic [TOTAL_W-1:0]  total_score,
  output logic [20:0]         combo,
  output logic [20:0]         note_cnt,
  output logic [20:0]         acc,
  output logic [2:0]          level,
`ifdef MAX_COMBO_EN
  output logic [20:0]         max_combo,
`endif
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_JUDGE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [20:0] total_lat;
  logic [20:0] base_acc;
  logic        miss;

  // Goal-side window arithmetic is one bit wider so it cannot wrap.
  logic [CLOCK_W:0] gt_ext;
  logic [CLOCK_W:0] goal_ext;
  logic [CLOCK_W:0] early_lim;
  logic [CLOCK_W:0] late_lim;
  logic             in_win;
  logic             late;
  logic             take_press;
  logic             take_miss;

  logic [20:0]        cnt_inc;
  logic               last_note;
  logic [21:0]        base_sum;
  logic [20:0]        base_nxt;
  logic [TOTAL_W+1:0] tot_sum;
  logic [TOTAL_W-1:0] tot_nxt;

  assign gt_ext    = {1'b0, game_time};
  assign goal_ext  = {1'b0, sc_goal_clock};
  assign early_lim = gt_ext + (CLOCK_W+1)'(EARLY_WIN);
  assign late_lim  = goal_ext + (CLOCK_W+1)'(MISS_WIN);
  assign in_win    = early_lim >= goal_ext;
  assign late      = gt_ext > late_lim;

  assign take_press = press_valid && in_win;
  assign take_miss  = !press_valid && late;

  assign cnt_inc   = note_cnt + 21'd1;
  assign last_note = cnt_inc == total_lat;

  // Saturating sums: any carry out of the register width clamps to all-ones.
  assign base_sum = {1'b0, base_acc} + {1'b0, sc_base_score};
  assign base_nxt = base_sum[21] ? '1 : base_sum[20:0];

  assign tot_sum = {2'b00, total_score}
                 + (TOTAL_W+2)'(sc_base_score)
                 + (TOTAL_W+2)'(sc_bonus_score);
  assign tot_nxt = (|tot_sum[TOTAL_W+1:TOTAL_W])
                 ? '1 : tot_sum[TOTAL_W-1:0];

  assign chart_idx          = note_cnt;
  assign sc_last_combo      = combo;
  assign sc_now_cnt         = note_cnt;
  assign sc_total_note      = total_lat;
  assign sc_last_base_score = base_acc;

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            nxt = (total_note == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (chart_valid) nxt = S_WAIT;
        end
        S_WAIT: begin
          if (take_press)     nxt = S_JUDGE;
          else if (take_miss) nxt = S_COMMIT;
        end
        S_JUDGE:  nxt = S_COMMIT;
        S_COMMIT: nxt = last_note ? S_DONE : S_FETCH;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      chart_req      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      total_lat      <= '0;
      base_acc       <= '0;
      miss           <= 1'b0;
      total_score    <= '0;
      combo          <= '0;
      note_cnt       <= '0;
      acc            <= 21'd10000;
      level          <= 3'd1;
      sc_clock       <= '0;
      sc_octave      <= '0;
      sc_note        <= '0;
      sc_length      <= '0;
      sc_goal_clock  <= '0;
      sc_goal_octave <= '0;
      sc_goal_note   <= '0;
      sc_goal_length <= '0;
`ifdef MAX_COMBO_EN
      max_combo      <= '0;
`endif
    end else begin
      state     <= nxt;
      chart_req <= nxt == S_FETCH;
      busy      <= (nxt == S_FETCH) || (nxt == S_WAIT)
                || (nxt == S_JUDGE) || (nxt == S_COMMIT);
      done      <= nxt == S_DONE;
      if (!abort) begin
        unique case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              total_lat   <= total_note;
              total_score <= '0;
              combo       <= '0;
              note_cnt    <= '0;
              base_acc    <= '0;
`ifdef MAX_COMBO_EN
              max_combo   <= '0;
`endif
            end
          end
          S_FETCH: begin
            if (chart_valid) begin
              sc_goal_clock  <= chart_clock;
              sc_goal_octave <= chart_octave;
              sc_goal_note   <= chart_note;
              sc_goal_length <= chart_length;
            end
          end
          S_WAIT: begin
            if (take_press) begin
              miss      <= 1'b0;
              sc_clock  <= game_time;
              sc_octave <= press_octave;
              sc_note   <= press_note;
              sc_length <= press_length;
            end else if (take_miss) begin
              // Inverted note guarantees a zero-score judgement.
              miss      <= 1'b1;
              sc_clock  <= game_time;
              sc_octave <= sc_goal_octave;
              sc_note   <= ~sc_goal_note;
              sc_length <= sc_goal_length;
            end
          end
          S_COMMIT: begin
            note_cnt <= cnt_inc;
            acc      <= sc_acc;
            level    <= sc_level;
            if (miss) begin
              combo <= '0;
            end else begin
              combo       <= sc_combo;
              base_acc    <= base_nxt;
              total_score <= tot_nxt;
`ifdef MAX_COMBO_EN
              if (sc_combo > max_combo) max_combo <= sc_combo;
`endif
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
